// File: rtl/rv_fmt_pkg.sv
// rv_fmt_pkg: shared RV32 encoding definitions for the immediate encoder.
// Contents:
//   - opcode constants (ir[6:0]) for the supported major opcodes
//   - fmt_e enum for the instruction format families
//   - NOP constant emitted in place of words with an unknown opcode
//   - fmt_of(): opcode -> format classification
//   - imm_range_err(): flags immediates that do not fit the chosen format
package rv_fmt_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  localparam logic [31:0] NOP = 32'h00000013;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: f = FMT_I;
      OP_STORE:                 f = FMT_S;
      OP_BRANCH:                f = FMT_B;
      OP_LUI, OP_AUIPC:         f = FMT_U;
      OP_JAL:                   f = FMT_J;
      OP_REG:                   f = FMT_R;
      default:                  f = FMT_BAD;
    endcase
    return f;
  endfunction

  // B and J immediates are already in halfword units, so B only has 12
  // significant bits and J has 20; U carries the upper 20 bits only.
  function automatic logic imm_range_err(input fmt_e f, input logic [31:0] imme);
    logic e;
    case (f)
      FMT_I, FMT_S, FMT_B: e = (imme[31:12] != 20'd0);
      FMT_U:               e = (imme[11:0] != 12'd0);
      FMT_J:               e = (imme[31:20] != 12'd0);
      FMT_R:               e = 1'b0;
      default:             e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/imm_enc_pack.sv
// imm_enc_pack: purely combinational packing of instruction fields into an
// RV32 instruction word according to the format family.
// Ports:
//   fmt     in  format family (FMT_BAD yields a NOP)
//   opcode  in  7-bit major opcode, placed in ir[6:0]
//   rd, rs1, rs2, funct3, funct7  in  register and function fields
//   imme    in  32-bit immediate in the core's immediate format
//   ir      out packed 32-bit instruction
import rv_fmt_pkg::*;

module imm_enc_pack (
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imme,
  output logic [31:0] ir
);

  // Out-of-range immediate bits simply fall off here; the error flag is
  // produced separately in stage 1.
  always_comb begin
    ir = NOP;
    case (fmt)
      FMT_I: ir = {imme[11:0], rs1, funct3, rd, opcode};
      FMT_S: ir = {imme[11:5], rs2, rs1, funct3, imme[4:0], opcode};
      FMT_B: ir = {imme[11], imme[9:4], rs2, rs1, funct3, imme[3:0], imme[10], opcode};
      FMT_U: ir = {imme[31:12], rd, opcode};
      FMT_J: ir = {imme[19], imme[9:0], imme[10], imme[18:11], rd, opcode};
      FMT_R: ir = {funct7, rs2, rs1, funct3, rd, opcode};
      default: ir = NOP;
    endcase
  end

endmodule

// File: rtl/imm_enc.sv
// imm_enc: two-stage valid/ready instruction encoder. Stage 1 registers the
// request, classifies the opcode and computes the range error; stage 2
// registers the packed instruction word and its error flag.
// Optional feature macro: IMM_ENC_STATS_EN (saturating emitted/error counters).
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   request handshake
//   opcode, rd, rs1, rs2, funct3, funct7, imme   request fields
//   out_valid/out_ready result handshake
//   ir, out_err         encoded word and its range/opcode error flag
//   enc_cnt, err_cnt    words / errored words emitted (zero without the macro)
import rv_fmt_pkg::*;

module imm_enc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imme,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      ir,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic        s1_valid;
  fmt_e        s1_fmt;
  logic        s1_err;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imme;
  logic [31:0] packed_ir;
  logic        s1_adv;
  logic        accept;

  // Stage 1 may hand over whenever stage 2 is empty or draining this cycle,
  // which gives flow-through backpressure and one word per cycle.
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= FMT_BAD;
      s1_err    <= 1'b0;
      s1_opcode <= 7'd0;
      s1_rd     <= 5'd0;
      s1_rs1    <= 5'd0;
      s1_rs2    <= 5'd0;
      s1_funct3 <= 3'd0;
      s1_funct7 <= 7'd0;
      s1_imme   <= 32'd0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_fmt    <= fmt_of(opcode);
      s1_err    <= imm_range_err(fmt_of(opcode), imme);
      s1_opcode <= opcode;
      s1_rd     <= rd;
      s1_rs1    <= rs1;
      s1_rs2    <= rs2;
      s1_funct3 <= funct3;
      s1_funct7 <= funct7;
      s1_imme   <= imme;
    end else if (s1_adv) begin
      s1_valid  <= 1'b0;
    end
  end

  imm_enc_pack u_pack (
    .fmt    (s1_fmt),
    .opcode (s1_opcode),
    .rd     (s1_rd),
    .rs1    (s1_rs1),
    .rs2    (s1_rs2),
    .funct3 (s1_funct3),
    .funct7 (s1_funct7),
    .imme   (s1_imme),
    .ir     (packed_ir)
  );

  // ir/out_err are only reloaded from a valid stage 1, so they stay stable
  // throughout a downstream stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ir        <= 32'd0;
      out_err   <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ir      <= packed_ir;
        out_err <= s1_err;
      end
    end
  end

`ifdef IMM_ENC_STATS_EN
  logic out_hs;
  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (out_hs) begin
      if (enc_cnt != '1) enc_cnt <= enc_cnt + 1'b1;
      if (out_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign enc_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// tb_imm_enc: directed testbench for imm_enc with hand-computed expected words.
module tb_imm_enc;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imme;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      ir;
  logic             out_err;
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  imm_enc #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imme      (imme),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ir        (ir),
    .out_err   (out_err),
    .enc_cnt   (enc_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] im);
    opcode   = op;
    rd       = d;
    rs1      = s1;
    rs2      = s2;
    funct3   = f3;
    funct7   = f7;
    imme     = im;
    in_valid = 1'b1;
  endtask

  // Single word with out_ready high: accepted at edge N, visible after N+1,
  // consumed at N+2.
  task automatic runWord(input string tag, input logic [31:0] exp_ir, input logic exp_err);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({tag, "_lat_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_ir"}, ir, exp_ir);
    checkOutput({tag, "_err"}, 32'(out_err), 32'(exp_err));
    @(posedge clk); #1;
    checkOutput({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] addi_word(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imme = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ir", ir, 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);

    applyStimulus(7'b1111111, 5'd1, 5'd2, 5'd3, 3'd1, 7'd0, 32'h0);
    runWord("bad", 32'h00000013, 1'b1);
`ifdef IMM_ENC_STATS_EN
    checkOutput("bad_enc_cnt", 32'(enc_cnt), 32'd1);
    checkOutput("bad_err_cnt", 32'(err_cnt), 32'd1);
`else
    checkOutput("bad_enc_cnt", 32'(enc_cnt), 32'd0);
    checkOutput("bad_err_cnt", 32'(err_cnt), 32'd0);
`endif

    applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    runWord("i_addi", 32'h00500093, 1'b0);
    applyStimulus(7'b0100011, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8);
    runWord("s_sw", 32'h0021A423, 1'b0);
    applyStimulus(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4);
    runWord("b_beq", 32'h00208463, 1'b0);
    applyStimulus(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    runWord("u_lui", 32'h123452B7, 1'b0);
    applyStimulus(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    runWord("u_range", 32'h123452B7, 1'b1);
    applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    runWord("j_jal", 32'h010000EF, 1'b0);
    applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000);
    runWord("j_range", 32'h000000EF, 1'b1);
    applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000);
    runWord("i_range", 32'h00000093, 1'b1);
    applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFF);
    runWord("r_add", 32'h002081B3, 1'b0);

    // Backpressure: two accepts fill the pipe, then a 3-cycle stall.
    out_ready = 1'b0;
    applyStimulus(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    checkOutput("bp_rdy0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    checkOutput("bp_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    checkOutput("bp_rdy_low", 32'(in_ready), 32'd0);
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_ir_w0", ir, addi_word(1));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("bp_stall_ir", ir, addi_word(1));
      checkOutput("bp_stall_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_rdy_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("bp_ir_w1", ir, addi_word(2));
    applyStimulus(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_ir_w2", ir, addi_word(3));
    checkOutput("bp_valid_w2", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    checkOutput("bp_ir_w3", ir, addi_word(4));
    checkOutput("bp_valid_w3", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    checkOutput("bp_empty", 32'(out_valid), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    applyStimulus(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    @(posedge clk); #1;
    applyStimulus(7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_enc_cnt", 32'(enc_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    applyStimulus(7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    runWord("post_rst", addi_word(7), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
